// File: rtl/alu_exec_unit_if.sv
// Sequencer <-> execute-stage handshake bundle for alu_exec_unit.
// The sequencer is the master; the execution unit is the slave.
interface alu_exec_unit_if #(parameter int WIDTH = 16);
  logic             start;
  logic [3:0]       operation;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             carry;
  logic             neg;
  logic             dbz;
  logic             illegal;

  modport master (
    output start, operation, a, b,
    input  busy, done, result, result_hi, zero, carry, neg, dbz, illegal
  );

  modport slave (
    input  start, operation, a, b,
    output busy, done, result, result_hi, zero, carry, neg, dbz, illegal
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ops finish in one cycle, multiply (shift-add)
// and divide (restoring) iterate one bit per cycle under a start/busy/done handshake.
module alu_exec_unit #(
  parameter int WIDTH = 16
) (
  input logic           clk,
  input logic           reset,
  alu_exec_unit_if.slave bus
);

  localparam int         CW     = $clog2(WIDTH + 1);
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_DIV = 4'd4;

  // State bits double as the busy/done output registers.
  typedef enum logic [1:0] {IDLE = 2'b00, ITER = 2'b01, DONE = 2'b10} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             carry;
    logic             neg;
    logic             dbz;
    logic             illegal;
  } res_t;

  // Divide reaches here only when the divisor is zero.
  function automatic res_t single_op(input logic [3:0] op, input logic [WIDTH-1:0] x,
                                     input logic [WIDTH-1:0] y);
    res_t                    r;
    logic [WIDTH:0]          s;
    logic signed [WIDTH-1:0] sx;
    logic signed [WIDTH-1:0] sy;
    r  = '0;
    s  = '0;
    sx = x;
    sy = y;
    case (op)
      4'd0, 4'd3: r = '0;
      4'd1: begin
        s       = {1'b0, x} + {1'b0, y};
        r.lo    = s[WIDTH-1:0];
        r.carry = s[WIDTH];
      end
      4'd2: begin
        r.lo    = x - y;
        r.carry = (x < y);
      end
      4'd4: begin
        r.lo  = '1;
        r.hi  = x;
        r.dbz = 1'b1;
      end
      4'd5: r.lo = y;
      4'd6: begin
        r.lo = y;
        r.hi = x;
      end
      4'd7: r.lo = x & y;
      4'd8: r.lo = x | y;
      4'd9: begin
        r.lo  = x - y;
        r.neg = (sx < sy);
      end
      default: r.illegal = 1'b1;
    endcase
    return r;
  endfunction

  // One multiply (shift-add) or divide (restoring) step on the {hi, lo} pair.
  function automatic logic [2*WIDTH-1:0] iter_step(input logic is_div,
                                                   input logic [WIDTH-1:0] hi,
                                                   input logic [WIDTH-1:0] lo,
                                                   input logic [WIDTH-1:0] m);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] sh;
    logic [WIDTH:0] trial;
    sum   = {1'b0, hi} + (lo[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    sh    = {hi, lo[WIDTH-1]};
    trial = sh - {1'b0, m};
    if (!is_div)
      return {sum, lo[WIDTH-1:1]};
    else if (!trial[WIDTH])
      return {trial[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};
    else
      return {sh[WIDTH-1:0], lo[WIDTH-2:0], 1'b0};
  endfunction

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic               is_div_q;
  logic [WIDTH-1:0]   m_q, hi_q, lo_q;
  logic [2*WIDTH-1:0] step;
  logic               accept, go_iter, last_iter;
  logic               busy, done;
  res_t               single;
  res_t               out_q;
  logic               zero_q;

  assign accept    = bus.start && (state_q == IDLE || state_q == DONE);
  assign go_iter   = (bus.operation == OP_MUL) || (bus.operation == OP_DIV && bus.b != '0);
  assign last_iter = (state_q == ITER) && (cnt_q == CW'(1));
  assign step      = iter_step(is_div_q, hi_q, lo_q, m_q);
  assign single    = single_op(bus.operation, bus.a, bus.b);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) state_d = go_iter ? ITER : DONE;
        else        state_d = IDLE;
      end
      ITER:    if (last_iter) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ITER);
    done = (state_q == DONE);
  end

  // Iteration datapath: operands latched on accept, no reset needed.
  always_ff @(posedge clk) begin
    if (accept && go_iter) begin
      is_div_q <= (bus.operation == OP_DIV);
      m_q      <= (bus.operation == OP_MUL) ? bus.a : bus.b;
      hi_q     <= '0;
      lo_q     <= (bus.operation == OP_MUL) ? bus.b : bus.a;
    end else if (state_q == ITER) begin
      {hi_q, lo_q} <= step;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                   cnt_q <= '0;
    else if (accept && go_iter)  cnt_q <= CW'(WIDTH);
    else if (state_q == ITER)    cnt_q <= cnt_q - 1'b1;
  end

  // Visible results change only on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q  <= '0;
      zero_q <= 1'b0;
    end else if (accept && !go_iter) begin
      out_q  <= single;
      zero_q <= (single.lo == '0);
    end else if (last_iter) begin
      out_q  <= {step, 4'b0000};
      zero_q <= (step[WIDTH-1:0] == '0);
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.result    = out_q.lo;
  assign bus.result_hi = out_q.hi;
  assign bus.zero      = zero_q;
  assign bus.carry     = out_q.carry;
  assign bus.neg       = out_q.neg;
  assign bus.dbz       = out_q.dbz;
  assign bus.illegal   = out_q.illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases, randomized ops against
// an arithmetic reference model, and handshake robustness scenarios.
module tb_alu_exec_unit;
  localparam int W = 16;
  typedef logic [2*W+4:0] vec_t;  // {hi, result, zero, carry, neg, dbz, illegal}

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   overlap  = 0;

  alu_exec_unit_if #(.WIDTH(W)) bus ();
  alu_exec_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(negedge clk) if (bus.busy === 1'b1 && bus.done === 1'b1) overlap++;

  localparam logic [67:0] DIR [14] = '{
    {4'h1, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000},
    {4'h2, 16'h0003, 16'h0005, 16'h0000, 16'hFFFE},
    {4'h6, 16'h1234, 16'hABCD, 16'h1234, 16'hABCD},
    {4'h7, 16'hF0F0, 16'h0FF0, 16'h0000, 16'h00F0},
    {4'h8, 16'hF0F0, 16'h0FF0, 16'h0000, 16'hFFF0},
    {4'h3, 16'h1234, 16'h5678, 16'h0626, 16'h0060},
    {4'h3, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001},
    {4'h4, 16'd1000, 16'd7,    16'd6,    16'd142},
    {4'h4, 16'd5,    16'd0,    16'd5,    16'hFFFF},
    {4'h9, 16'hFFFF, 16'h0001, 16'h0000, 16'hFFFE},
    {4'h9, 16'h0042, 16'h0042, 16'h0000, 16'h0000},
    {4'hC, 16'h1234, 16'h5678, 16'h0000, 16'h0000},
    {4'h0, 16'h1234, 16'h5678, 16'h0000, 16'h0000},
    {4'h5, 16'h0001, 16'hBEEF, 16'h0000, 16'hBEEF}
  };

  function automatic vec_t model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] r, h;
    logic         c, n, d, il;
    logic [W:0]   s;
    logic [2*W-1:0] p;
    r = '0; h = '0; c = 0; n = 0; d = 0; il = 0;
    case (op)
      4'd0: r = '0;
      4'd1: begin s = x + y; r = s[W-1:0]; c = s[W]; end
      4'd2: begin r = x - y; c = (x < y); end
      4'd3: begin p = x * y; r = p[W-1:0]; h = p[2*W-1:W]; end
      4'd4: if (y == 0) begin r = '1; h = x; d = 1; end
            else begin r = x / y; h = x % y; end
      4'd5: r = y;
      4'd6: begin r = y; h = x; end
      4'd7: r = x & y;
      4'd8: r = x | y;
      4'd9: begin r = x - y; n = ($signed(x) < $signed(y)); end
      default: il = 1;
    endcase
    return {h, r, (r == 0), c, n, d, il};
  endfunction

  function automatic int lat_of(input logic [3:0] op, input logic [W-1:0] y);
    return (op == 4'd3 || (op == 4'd4 && y != 0)) ? W + 1 : 1;
  endfunction

  function automatic vec_t observed();
    return {bus.result_hi, bus.result, bus.zero, bus.carry, bus.neg, bus.dbz, bus.illegal};
  endfunction

  // Issue one op, scramble inputs after acceptance, wait (bounded) for done.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int lat, output int nbusy);
    @(negedge clk);
    bus.operation = op; bus.a = x; bus.b = y; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.operation = 4'($urandom); bus.a = 16'($urandom); bus.b = 16'($urandom);
    lat = 1; nbusy = 0;
    while (bus.done !== 1'b1 && lat <= 40) begin
      if (bus.busy === 1'b1) nbusy++;
      @(negedge clk);
      lat++;
    end
    if (bus.done !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.start = 1'b1; bus.operation = 4'd1; bus.a = 16'd1; bus.b = 16'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.done, observed()} !== '0) begin
      n_fail++; $display("FAIL reset_hold: got %h expected 0", {bus.busy, bus.done, observed()});
    end
    reset = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.done, observed()} !== '0) begin
      n_fail++; $display("FAIL reset_release: got %h expected 0", {bus.busy, bus.done, observed()});
    end
  endtask

  task automatic test_directed();
    logic [67:0] v;
    logic [3:0]  op;
    logic [W-1:0] x, y, eh, el;
    int lat, nb;
    for (int i = 0; i < 14; i++) begin
      v = DIR[i];
      {op, x, y, eh, el} = v;
      run_op(op, x, y, lat, nb);
      n_checks++;
      if (lat !== lat_of(op, y) || nb !== lat_of(op, y) - 1) begin
        n_fail++; $display("FAIL dir_lat[%0d] op %h: got lat %0d busy %0d expected lat %0d", i, op, lat, nb, lat_of(op, y));
      end
      n_checks++;
      if ({bus.result_hi, bus.result} !== {eh, el}) begin
        n_fail++; $display("FAIL dir_value[%0d] op %h: got %h expected %h", i, op, {bus.result_hi, bus.result}, {eh, el});
      end
      n_checks++;
      if (observed() !== model(op, x, y)) begin
        n_fail++; $display("FAIL dir_flags[%0d] op %h: got %h expected %h", i, op, observed(), model(op, x, y));
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic [W-1:0] x, y;
    vec_t exp;
    int lat, nb;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      x  = 16'($urandom);
      y  = 16'($urandom);
      if ($urandom_range(0, 5) == 0) y = '0;
      if ($urandom_range(0, 5) == 0) y = x;
      exp = model(op, x, y);
      run_op(op, x, y, lat, nb);
      n_checks++;
      if (lat !== lat_of(op, y)) begin
        n_fail++; $display("FAIL rnd_lat[%0d] op %h: got %0d expected %0d", i, op, lat, lat_of(op, y));
      end
      n_checks++;
      if (observed() !== exp) begin
        n_fail++; $display("FAIL rnd_value[%0d] op %h a %h b %h: got %h expected %h", i, op, x, y, observed(), exp);
      end
      @(negedge clk);
      n_checks++;
      if ({bus.done, observed()} !== {1'b0, exp}) begin
        n_fail++; $display("FAIL rnd_hold[%0d]: got %h expected %h", i, {bus.done, observed()}, {1'b0, exp});
      end
    end
  endtask

  task automatic test_start_during_iter();
    int lat;
    @(negedge clk);
    bus.operation = 4'd3; bus.a = 16'h1234; bus.b = 16'h5678; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (bus.done !== 1'b1 && lat <= 40) begin
      if (lat == 5) begin bus.start = 1'b1; bus.operation = 4'd1; bus.a = 16'h0101; bus.b = 16'h0202; end
      else bus.start = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (bus.done !== 1'b1) lat = -1;
    n_checks++;
    if (lat !== W + 1) begin
      n_fail++; $display("FAIL ign_lat: got %0d expected %0d", lat, W + 1);
    end
    n_checks++;
    if (observed() !== model(4'd3, 16'h1234, 16'h5678)) begin
      n_fail++; $display("FAIL ign_value: got %h expected %h", observed(), model(4'd3, 16'h1234, 16'h5678));
    end
    @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_fail++; $display("FAIL ign_after: got busy/done %b expected 00", {bus.busy, bus.done});
    end
  endtask

  task automatic test_reset_mid_iter();
    int lat, nb, spurious;
    @(negedge clk);
    bus.operation = 4'd4; bus.a = 16'd1000; bus.b = 16'd7; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_busy: got %b expected 1", bus.busy);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if ({bus.busy, bus.done, observed()} !== '0) begin
      n_fail++; $display("FAIL mid_reset: got %h expected 0", {bus.busy, bus.done, observed()});
    end
    spurious = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) spurious++;
    end
    n_checks++;
    if (spurious !== 0) begin
      n_fail++; $display("FAIL mid_idle: got %0d active cycles expected 0", spurious);
    end
    run_op(4'd4, 16'd1000, 16'd7, lat, nb);
    n_checks++;
    if (lat !== W + 1 || observed() !== model(4'd4, 16'd1000, 16'd7)) begin
      n_fail++; $display("FAIL mid_rerun: got lat %0d value %h expected lat %0d value %h", lat, observed(), W + 1, model(4'd4, 16'd1000, 16'd7));
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    bus.operation = 4'd3; bus.a = 16'h1234; bus.b = 16'h5678; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.a = 16'hFFFF; bus.b = 16'hFFFF;
    lat = 1;
    while (bus.done !== 1'b1 && lat <= 40) begin @(negedge clk); lat++; end
    if (bus.done !== 1'b1) lat = -1;
    n_checks++;
    if (lat !== W + 1 || observed() !== model(4'd3, 16'h1234, 16'h5678)) begin
      n_fail++; $display("FAIL b2b_first: got lat %0d value %h expected lat %0d value %h", lat, observed(), W + 1, model(4'd3, 16'h1234, 16'h5678));
    end
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0; bus.a = 16'h0003; bus.b = 16'h0005;
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_accept: got busy %b expected 1", bus.busy);
    end
    lat = 1;
    while (bus.done !== 1'b1 && lat <= 40) begin @(negedge clk); lat++; end
    if (bus.done !== 1'b1) lat = -1;
    n_checks++;
    if (lat !== W + 1 || observed() !== model(4'd3, 16'hFFFF, 16'hFFFF)) begin
      n_fail++; $display("FAIL b2b_second: got lat %0d value %h expected lat %0d value %h", lat, observed(), W + 1, model(4'd3, 16'hFFFF, 16'hFFFF));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_during_iter();
    test_reset_mid_iter();
    test_back_to_back();
    n_checks++;
    if (overlap !== 0) begin
      n_fail++; $display("FAIL busy_done_overlap: got %0d cycles expected 0", overlap);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
